// File: rtl/exec_int_sched_pkg.sv
// Shared types for the integer issue controller: opcode/funct7 constants,
// latency class and the in-flight tag entry carried down the tag pipeline.
package exec_int_sched_pkg;

   localparam int XLEN = 64;

   localparam logic [4:0] OPC_OP        = 5'b01100;
   localparam logic [4:0] OPC_OP_32     = 5'b01110;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic {
      LAT_ALU = 1'b0,
      LAT_MUL = 1'b1
   } lat_class_t;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       is_mul;
      logic       killed;
   } tag_t;

   // Register-register M-extension ops take the two-cycle multiplier path.
   function automatic lat_class_t classify(input logic [4:0] opcode,
                                           input logic [6:0] funct7);
      if ((opcode == OPC_OP || opcode == OPC_OP_32) && funct7 == FUNCT7_MULDIV)
         return LAT_MUL;
      return LAT_ALU;
   endfunction

endpackage

// File: rtl/int_scoreboard.sv
// Busy-register vector for the two tag slots plus the RAW check, with a bypass
// for a slot whose result is being written back cleanly this cycle.
module int_scoreboard (
   input  logic        s1_live,
   input  logic [4:0]  s1_rd,
   input  logic        s1_bypass,
   input  logic        s2_live,
   input  logic [4:0]  s2_rd,
   input  logic        s2_bypass,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic [31:0] rd_busy,
   output logic        raw_hazard
);

   logic [31:0] s1_vec;
   logic [31:0] s2_vec;
   logic [31:0] hold_vec;

   always_comb begin
      s1_vec = '0;
      s2_vec = '0;
      if (s1_live && s1_rd != 5'd0) s1_vec[s1_rd] = 1'b1;
      if (s2_live && s2_rd != 5'd0) s2_vec[s2_rd] = 1'b1;
   end

   assign rd_busy = s1_vec | s2_vec;

   // A slot retiring with good data this cycle no longer blocks its readers.
   assign hold_vec = (s1_bypass ? 32'd0 : s1_vec) | (s2_bypass ? 32'd0 : s2_vec);

   assign raw_hazard = (rs1 != 5'd0 && hold_vec[rs1]) ||
                       (rs2 != 5'd0 && hold_vec[rs2]);

endmodule

// File: rtl/exec_int_sched.sv
// Issue controller in front of exec_int: handshake with decode, tag pipeline
// pairing untagged results with rd, MUL/ALU latency rules, RAW stall and flush.
module exec_int_sched
   import exec_int_sched_pkg::*;
#(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             in_opcode,
   input  logic [6:0]             in_funct7,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_rs1,
   input  logic [4:0]             in_rs2,
   output logic                   issue_valid,
   input  logic                   int_output_valid,
   input  logic                   int_exception,
   input  logic [3:0]             int_trap_cause,
   input  logic [XLEN-1:0]        int_result,
   output logic                   wb_valid,
   output logic [4:0]             wb_rd,
   output logic [XLEN-1:0]        wb_data,
   output logic                   wb_exception,
   output logic [3:0]             wb_trap_cause,
   output logic [31:0]            rd_busy,
   output logic                   protocol_error,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   tag_t s1;
   tag_t s2;

   logic in_is_mul;
   logic s1_mul_pending;
   logic s1_done;
   logic s2_done;
   logic completing;
   logic done_killed;
   logic good_wb;
   logic raw_hazard;

   assign in_is_mul      = (classify(in_opcode, in_funct7) == LAT_MUL);
   assign s1_mul_pending = s1.v && s1.is_mul;

   // S2 only ever holds multiplies; at most one slot retires per cycle.
   assign s1_done     = s1.v && !s1.is_mul;
   assign s2_done     = s2.v && s2.is_mul;
   assign completing  = s1_done || s2_done;
   assign done_killed = s1_done ? s1.killed : s2.killed;

   assign wb_valid      = !rst && int_output_valid && completing && !done_killed;
   assign wb_rd         = s1_done ? s1.rd : s2.rd;
   assign wb_data       = int_result;
   assign wb_exception  = int_exception;
   assign wb_trap_cause = int_trap_cause;
   assign good_wb       = wb_valid && !int_exception;

   int_scoreboard u_int_scoreboard (
      .s1_live    (s1.v && !s1.killed),
      .s1_rd      (s1.rd),
      .s1_bypass  (s1_done && good_wb),
      .s2_live    (s2.v && !s2.killed),
      .s2_rd      (s2.rd),
      .s2_bypass  (s2_done && good_wb),
      .rs1        (in_rs1),
      .rs2        (in_rs2),
      .rd_busy    (rd_busy),
      .raw_hazard (raw_hazard)
   );

   // Issuing behind a MUL in S1 would make exec_int drop the pending product.
   assign in_ready    = !rst && !flush && !s1_mul_pending && !raw_hazard;
   assign issue_valid = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1             <= '0;
         s2             <= '0;
         protocol_error <= 1'b0;
         stall_cycles   <= '0;
      end else begin
         if (issue_valid)
            s1 <= '{v: 1'b1, rd: in_rd, is_mul: in_is_mul, killed: 1'b0};
         else
            s1 <= '0;

         if (s1_mul_pending)
            s2 <= '{v: 1'b1, rd: s1.rd, is_mul: 1'b1, killed: s1.killed | flush};
         else
            s2 <= '0;

         if (int_output_valid != completing)
            protocol_error <= 1'b1;

         if (in_valid && !in_ready && !flush && stall_cycles != '1)
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_exec_int_sched.sv
// Bench for exec_int_sched: acts as exec_int, tracks in-flight ops by due cycle
// and checks every output each cycle against that abstract model.
module tb_exec_int_sched;
   import exec_int_sched_pkg::*;

   localparam int SW = 32;
   localparam logic [4:0] T_OP     = 5'b01100;
   localparam logic [4:0] T_OP_32  = 5'b01110;
   localparam logic [4:0] T_OP_IMM = 5'b00100;

   logic            clk = 1'b0;
   logic            rst, flush, in_valid, in_ready, issue_valid;
   logic [4:0]      in_opcode, in_rd, in_rs1, in_rs2;
   logic [6:0]      in_funct7;
   logic            int_output_valid, int_exception;
   logic [3:0]      int_trap_cause;
   logic [XLEN-1:0] int_result;
   logic            wb_valid, wb_exception, protocol_error;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [3:0]      wb_trap_cause;
   logic [31:0]     rd_busy;
   logic [SW-1:0]   stall_cycles;

   always #5 clk = ~clk;

   exec_int_sched #(.STALL_CNT_W(SW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .issue_valid(issue_valid),
      .int_output_valid(int_output_valid), .int_exception(int_exception),
      .int_trap_cause(int_trap_cause), .int_result(int_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_exception(wb_exception), .wb_trap_cause(wb_trap_cause),
      .rd_busy(rd_busy), .protocol_error(protocol_error),
      .stall_cycles(stall_cycles)
   );

   typedef struct {
      int rd;
      int issued;
      int due;
      bit is_mul;
      bit killed;
   } op_t;

   op_t           q[$];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            m_err = 1'b0;
   logic [SW-1:0] m_stall = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, play exec_int, check outputs, advance model.
   task automatic step(input bit r, input bit f, input bit v,
                       input logic [4:0] opc, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit force_ov, input bit drop_ov, input bit force_exc);
      int di;
      bit has_due, ov, exc, wbv, good, mulblk, raw, ready, imul, dkill;
      int drd;
      logic [3:0]      cause;
      logic [XLEN-1:0] res;
      logic [31:0]     busy;

      di = -1;
      foreach (q[i]) if (q[i].due == cyc) di = i;
      has_due = (di >= 0);
      dkill   = 1'b0;
      drd     = 0;
      if (has_due) begin
         dkill = q[di].killed;
         drd   = q[di].rd;
      end
      ov    = (has_due && !drop_ov && !r) || force_ov;
      exc   = ov && (force_exc || $urandom_range(0, 7) == 0);
      cause = force_exc ? 4'd2 : (exc ? 4'($urandom_range(0, 15)) : 4'd0);
      res   = {$urandom, $urandom};

      rst = r; flush = f; in_valid = v; in_opcode = opc; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      int_output_valid = ov; int_exception = exc; int_trap_cause = cause; int_result = res;

      wbv    = !r && ov && has_due && !dkill;
      good   = wbv && !exc;
      mulblk = 1'b0;
      raw    = 1'b0;
      busy   = '0;
      foreach (q[i]) begin
         if (q[i].is_mul && q[i].issued == cyc - 1) mulblk = 1'b1;
         if (!q[i].killed && q[i].rd != 0) begin
            busy[q[i].rd] = 1'b1;
            if (!(i == di && good)) begin
               if (rs1 != 0 && q[i].rd == int'(rs1)) raw = 1'b1;
               if (rs2 != 0 && q[i].rd == int'(rs2)) raw = 1'b1;
            end
         end
      end
      ready = !r && !f && !mulblk && !raw;
      imul  = (opc == T_OP || opc == T_OP_32) && f7 == 7'b0000001;

      #4;
      chk("in_ready", in_ready, ready);
      chk("issue_valid", issue_valid, v && ready);
      chk("wb_valid", wb_valid, wbv);
      if (wbv) begin
         chk("wb_rd", wb_rd, drd);
         chk("wb_data", wb_data, res);
         chk("wb_exception", wb_exception, exc);
         chk("wb_trap_cause", wb_trap_cause, cause);
      end
      chk("rd_busy", rd_busy, busy);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("protocol_error", protocol_error, m_err);

      if (r) begin
         q.delete();
         m_err   = 1'b0;
         m_stall = '0;
      end else begin
         if (ov != has_due) m_err = 1'b1;
         if (v && !ready && !f && m_stall != '1) m_stall++;
         if (has_due) q.delete(di);
         if (f) foreach (q[i]) q[i].killed = 1'b1;
         if (v && ready)
            q.push_back('{rd: int'(rd), issued: cyc, due: cyc + (imul ? 2 : 1),
                          is_mul: imul, killed: 1'b0});
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   task automatic op(input logic [4:0] opc, input logic [6:0] f7,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      step(0, 0, 1, opc, f7, rd, rs1, rs2, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct7 = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; int_output_valid = 1'b0;
      int_exception = 1'b0; int_trap_cause = '0; int_result = '0;
      repeat (2) @(posedge clk);
      #1;
      // reset state, with an op presented that must not be accepted
      step(1, 0, 1, T_OP_IMM, 7'd0, 5'd5, 5'd0, 5'd0, 0, 0, 0);

      // ALU result pairs with rd one cycle later
      op(T_OP_IMM, 7'd0, 5'd5, 5'd1, 5'd0);
      idle(); idle();
      // MUL blocks the following cycle; ADD issues after
      op(T_OP, 7'b0000001, 5'd7, 5'd0, 5'd0);
      op(T_OP, 7'd0, 5'd8, 5'd1, 5'd2);
      op(T_OP, 7'd0, 5'd8, 5'd1, 5'd2);
      idle(); idle();
      // RAW bypass after ALU, stall behind MUL
      op(T_OP, 7'd0, 5'd3, 5'd0, 5'd0);
      op(T_OP, 7'd0, 5'd10, 5'd3, 5'd0);
      idle();
      op(T_OP_32, 7'b0000001, 5'd3, 5'd0, 5'd0);
      op(T_OP, 7'd0, 5'd11, 5'd3, 5'd0);
      op(T_OP, 7'd0, 5'd11, 5'd3, 5'd0);
      idle(); idle();
      // flush kills a MUL in flight
      op(T_OP, 7'b0000001, 5'd9, 5'd0, 5'd0);
      step(0, 1, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      op(T_OP, 7'd0, 5'd12, 5'd9, 5'd0);
      idle(); idle();
      // trapped op: exception and cause passed through, rd released
      op(T_OP_32, 7'd0, 5'd4, 5'd0, 5'd0);
      step(0, 0, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      idle();
      // spurious result sets the sticky error
      step(0, 0, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      repeat (3) idle();
      step(1, 0, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      // missing result also sets it
      op(T_OP_IMM, 7'd0, 5'd6, 5'd0, 5'd0);
      step(0, 0, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      idle(); idle();
      step(1, 0, 0, T_OP_IMM, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

      // randomized traffic with occasional flush and reset
      for (int n = 0; n < 800; n++) begin
         logic [4:0] opc;
         logic [6:0] f7;
         int sel;
         sel = $urandom_range(0, 2);
         opc = (sel == 0) ? T_OP : (sel == 1) ? T_OP_32 : T_OP_IMM;
         sel = $urandom_range(0, 2);
         f7  = (sel == 0) ? 7'b0000001 : (sel == 1) ? 7'b0000000 : 7'b0100000;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 7, opc, f7,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              0, 0, 0);
      end
      idle(); idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exec_int_sched.md
Name: exec_int_sched

Overview:
- Issue controller in front of exec_int.
- Accepts integer ops from decode with a valid/ready handshake and forwards them to exec_int (input_valid/input_is_int).
- Tracks in-flight destination registers, since exec_int has no tags. Pairs each exec_int result with its rd for writeback.
- Enforces exec_int's latency rules (ALU 1 cycle, MUL 2 cycles, no overlap that would drop a pending MUL result), RAW stalls and flush.

Parameters:
- STALL_CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all in-flight ops; no wb for them
- in_valid  in  1  decode has an int op
- in_ready  out  1  op accepted this cycle when in_valid&&in_ready
- in_opcode  in  5  opcode[6:2]
- in_funct7  in  7  funct7
- in_rd  in  5  destination register
- in_rs1  in  5  source 1 (for RAW check)
- in_rs2  in  5  source 2 (for RAW check)
- issue_valid  out  1  drives exec_int input_valid and input_is_int
- int_output_valid  in  1  exec_int_output_valid
- int_exception  in  1  exec_int_exception
- int_trap_cause  in  4  exec_int_trap_cause
- int_result  in  XLEN  exec_int_result
- wb_valid  out  1  writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  XLEN  writeback data
- wb_exception  out  1  op trapped; wb_rd must not be written
- wb_trap_cause  out  4  trap cause
- rd_busy  out  32  scoreboard; bit0 always 0
- protocol_error  out  1  sticky: unexpected or missing int_output_valid
- stall_cycles  out  STALL_CNT_W  cycles with in_valid&&!in_ready

Behaviour:
- Classification: is_mul = (in_opcode==opcodes::OP || in_opcode==opcodes::OP_32) && in_funct7==7'b0000001. Latency is 2 for is_mul, 1 otherwise.
- issue_valid = in_valid && in_ready. This is combinational and feeds exec_int the same cycle.
- Tag pipeline:
  - S1 holds {v, rd, is_mul, killed}. It is loaded on each issue.
  - S2 holds {v, rd, killed}. It is loaded from S1 when S1.is_mul.
  - A non-mul in S1 completes next cycle; a mul in S2 completes next cycle.
  - Completing entry: S1 if S1.v && !S1.is_mul, else S2 if S2.v. Both cannot be completion candidates in one cycle, by construction.
- in_ready = !rst && !flush && !S1_mul_pending && !raw_hazard.
  - S1_mul_pending = S1.v && S1.is_mul. This blocks issue the cycle after a mul issue, because exec_int would discard the pending mul.
  - raw_hazard = (in_rs1!=0 && rd_busy[in_rs1]) || (in_rs2!=0 && rd_busy[in_rs2]), with bypass from completing wb. A source whose only busy entry completes this cycle is not a hazard only if wb_valid && !wb_exception. No bypass is done otherwise.
  - WAW needs no stall: in-order completion.
- rd_busy:
  - Set bit in_rd on issue when in_rd!=0.
  - Clear on completion of the entry that owns it.
  - Derivation: rd_busy is the OR of decoded non-killed S1/S2 rd.
- Writeback (registered on the same cycle as int_output_valid, i.e. comb passthrough):
  - wb_valid = int_output_valid && completing entry valid && !killed.
  - wb_rd = entry.rd; wb_data = int_result; wb_exception and wb_trap_cause pass through.
- Flush:
  - Marks S1/S2 killed, and rd_busy drops to 0 next cycle.
  - Entries still retire against int_output_valid but produce no wb_valid.
  - in_ready=0 during the flush cycle.
- protocol_error sets when either condition holds, and is cleared only by rst:
  - int_output_valid arrives with no completing entry.
  - A completing entry sees int_output_valid==0.
- stall_cycles: saturating counter, increments on in_valid && !in_ready && !flush.
- Reset values: S1.v=S2.v=0, rd_busy=0, protocol_error=0, stall_cycles=0, wb_valid=0, issue_valid=0.
- Reset mid-operation discards all entries. exec_int resets concurrently, so no stray outputs follow.

Decomposition:
- Reuse the opcodes package (OP, OP_32).
- Add to the shared core package:
  - funct7 constant FUNCT7_MULDIV=7'b0000001
  - latency-class typedef (LAT_ALU, LAT_MUL)
  - tag entry struct {v, rd, is_mul, killed}
- One sub-module, int_scoreboard: 32-bit busy vector and RAW check with bypass.

Test Plan:
- ADDI rd=5 issued at t; exec_int returns 0x2A at t+1 -> wb_valid at t+1, wb_rd=5, wb_data=0x2A; rd_busy[5]=1 only during t+1.
- MUL rd=7 at t, ADD rd=8 presented at t+1 -> in_ready=0 at t+1; wb rd=7 at t+2; ADD issues at t+2, wb rd=8 at t+3; stall_cycles=1.
- ADD rd=3 at t, then ADD rs1=3 at t+1 -> bypass allows issue at t+1. MUL rd=3 at t then rs1=3 -> stall until t+2 issue.
- MUL rd=9 at t, flush at t+1 -> int_output_valid at t+2 yields wb_valid=0; rd_busy=0 at t+2; protocol_error stays 0.
- OP_32 funct3=010 (illegal) rd=4 -> wb_valid=1, wb_exception=1, wb_trap_cause=2 (EXC_ILLEGAL_INSTR); rd_busy[4] cleared.
- Force int_output_valid=1 with no issue -> protocol_error=1, stays 1 until rst.
